// File: rtl/perf_counter_display.sv
// Performance-monitor counters plus a display channel selector with live, frozen-snapshot and
// timed auto-rotate modes, feeding one registered 32-bit value to the 7-segment driver.
module perf_counter_display #(
    parameter int NUM_EVT    = 6,
    parameter int NUM_EXT    = 3,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = 5,
    parameter int ROT_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [NUM_EVT-1:0]     evt,
    input  logic [32*NUM_EXT-1:0]  ext_data,
    input  logic [SEL_W-1:0]       sel,
    input  logic [1:0]             mode,
    input  logic                   clr,
    output logic [31:0]            disp_data,
    output logic [SEL_W-1:0]       disp_idx,
    output logic [NUM_EVT-1:0]     ovf
);

    localparam int NUM_CH   = NUM_EXT + NUM_EVT;
    localparam int NUM_SLOT = 2 ** SEL_W;
    localparam int ROT_W    = $clog2(ROT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg    [NUM_EVT];
    logic [CNT_W-1:0] shadow_reg [NUM_EVT];
    logic [NUM_EVT-1:0] ovf_reg;
    logic               prev_frz_reg;
    logic               prev_rot_reg;
    logic [SEL_W-1:0]   rot_idx_reg;
    logic [ROT_W-1:0]   timer_reg;
    logic [31:0]        disp_data_reg;
    logic [SEL_W-1:0]   disp_idx_reg;

    logic frz_mode, rot_mode, frz_entry, rot_entry, use_shadow;
    logic [SEL_W-1:0] cur_rot, disp_sel;
    logic [ROT_W-1:0] cur_timer;

    assign frz_mode   = (mode == 2'b01);
    assign rot_mode   = (mode == 2'b10);
    assign frz_entry  = frz_mode && !prev_frz_reg;
    assign rot_entry  = rot_mode && !prev_rot_reg;
    // On the freeze entry cycle the live count equals the value being snapshotted.
    assign use_shadow = frz_mode && prev_frz_reg;

    // The entry cycle itself is slot 0 of channel 0.
    assign cur_rot   = rot_entry ? '0 : rot_idx_reg;
    assign cur_timer = rot_entry ? '0 : timer_reg;
    assign disp_sel  = rot_mode ? cur_rot : sel;

    logic [31:0] chan_val [NUM_SLOT];

    generate
        for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_chan
            if (gi < NUM_EXT) begin : g_ext
                assign chan_val[gi] = ext_data[32*gi +: 32];
            end else if (gi < NUM_CH) begin : g_cnt
                assign chan_val[gi] = use_shadow ? 32'(shadow_reg[gi-NUM_EXT])
                                                 : 32'(cnt_reg[gi-NUM_EXT]);
            end else begin : g_none
                assign chan_val[gi] = 32'h0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EVT; i++) begin
            if (rst || clr) begin
                cnt_reg[i] <= '0;
                ovf_reg[i] <= 1'b0;
            end else if (run && evt[i]) begin
                if (cnt_reg[i] != CNT_MAX)
                    cnt_reg[i] <= cnt_reg[i] + 1'b1;
                else
                    ovf_reg[i] <= 1'b1;
            end
            if (rst)
                shadow_reg[i] <= '0;
            else if (frz_entry)
                shadow_reg[i] <= cnt_reg[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_frz_reg  <= 1'b0;
            prev_rot_reg  <= 1'b0;
            rot_idx_reg   <= '0;
            timer_reg     <= '0;
            disp_data_reg <= 32'h0;
            disp_idx_reg  <= '0;
        end else begin
            prev_frz_reg  <= frz_mode;
            prev_rot_reg  <= rot_mode;
            if (rot_mode) begin
                if (cur_timer == ROT_W'(ROT_CYCLES - 1)) begin
                    timer_reg   <= '0;
                    rot_idx_reg <= (cur_rot == SEL_W'(NUM_CH - 1)) ? '0 : cur_rot + 1'b1;
                end else begin
                    timer_reg   <= cur_timer + 1'b1;
                    rot_idx_reg <= cur_rot;
                end
            end
            disp_data_reg <= chan_val[disp_sel];
            disp_idx_reg  <= disp_sel;
        end
    end

    assign disp_data = disp_data_reg;
    assign disp_idx  = disp_idx_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_perf_counter_display.sv
// Directed bench for perf_counter_display: reset/live select, counting, saturation,
// freeze snapshot, auto-rotate sequencing and reset during rotate.
module tb_perf_counter_display;

    localparam int NUM_EVT = 6;
    localparam int NUM_EXT = 3;
    localparam int SEL_W   = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  run;
    logic [NUM_EVT-1:0]    evt;
    logic [32*NUM_EXT-1:0] ext_data;
    logic [SEL_W-1:0]      sel;
    logic [1:0]            mode;
    logic                  clr;
    logic [31:0]           disp_data;
    logic [SEL_W-1:0]      disp_idx;
    logic [NUM_EVT-1:0]    ovf;

    int total = 0;
    int bad   = 0;

    perf_counter_display #(
        .NUM_EVT(NUM_EVT), .NUM_EXT(NUM_EXT), .CNT_W(8), .SEL_W(SEL_W), .ROT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .evt(evt), .ext_data(ext_data), .sel(sel),
        .mode(mode), .clr(clr), .disp_data(disp_data), .disp_idx(disp_idx), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s val=%h", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected display value per channel during rotate (ext live, counters live)
    logic [31:0] rot_exp [9];

    initial begin
        rst = 1'b1; run = 1'b0; evt = '0; clr = 1'b0; mode = 2'b00; sel = 5'd1;
        ext_data = '0;
        ext_data[63:32] = 32'h0040_0010;

        // Reset and live select
        tick();
        check("rst_data0", disp_data, 32'h0);
        tick();
        check("rst_data1", disp_data, 32'h0);
        check("rst_idx", 32'(disp_idx), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();
        check("live_ext1", disp_data, 32'h0040_0010);
        check("live_idx1", 32'(disp_idx), 32'd1);
        sel = 5'd31;
        tick();
        check("live_sel31", disp_data, 32'h0);
        check("live_idx31", 32'(disp_idx), 32'd31);

        // Counting: 10 pulses with run, 5 ignored without
        sel = 5'd5; run = 1'b1; evt = 6'b000100;
        tick(10);
        run = 1'b0;
        tick(5);
        evt = '0;
        tick();
        check("cnt_10", disp_data, 32'd10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_lag", disp_data, 32'd10);
        tick();
        check("clr_zero", disp_data, 32'd0);

        // Saturation on an 8-bit counter
        sel = 5'd3; run = 1'b1; evt = 6'b000001;
        tick(300);
        evt = '0;
        tick();
        check("sat_ff", disp_data, 32'h0000_00FF);
        check("sat_ovf", 32'(ovf), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);
        evt = 6'b000001;
        tick(3);
        tick();
        check("cnt_3", disp_data, 32'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0; evt = '0;
        tick();
        check("clr_wins", disp_data, 32'd0);
        check("clr_wins_ovf", 32'(ovf), 32'd0);

        // Freeze: counter 3 at 100, keep counting while frozen
        sel = 5'd6; evt = 6'b001000;
        tick(100);
        evt = '0;
        tick();
        check("frz_pre", disp_data, 32'd100);
        mode = 2'b01; evt = 6'b001000;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("frz_hold%0d", k), disp_data, 32'd100);
        end
        evt = '0;
        sel = 5'd1; ext_data[63:32] = 32'hDEAD_BEEF;
        tick();
        check("frz_ext_live", disp_data, 32'hDEAD_BEEF);
        sel = 5'd6; mode = 2'b00;
        tick();
        check("frz_exit", disp_data, 32'd120);

        // Auto-rotate: 9 channels, 4 cycles each, sel ignored
        ext_data[31:0] = 32'h1111_1111; ext_data[95:64] = 32'h2222_2222;
        rot_exp = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222,
                    32'd0, 32'd0, 32'd0, 32'd120, 32'd0, 32'd0};
        mode = 2'b10;
        for (int k = 0; k < 40; k++) begin
            sel = 5'($urandom_range(0, 31));
            tick();
            check($sformatf("rot_idx%0d", k), 32'(disp_idx), 32'((k / 4) % 9));
            check($sformatf("rot_dat%0d", k), disp_data, rot_exp[(k / 4) % 9]);
        end
        sel = 5'd4; mode = 2'b00;
        tick();
        check("rot_exit_idx", 32'(disp_idx), 32'd4);

        // Reset mid-rotate, then re-entry starts at channel 0
        mode = 2'b10;
        tick(21);
        check("rot5_idx", 32'(disp_idx), 32'd5);
        rst = 1'b1;
        tick();
        check("rst_rot_idx", 32'(disp_idx), 32'd0);
        check("rst_rot_data", disp_data, 32'h0);
        rst = 1'b0;
        tick();
        check("reent_idx0", 32'(disp_idx), 32'd0);
        tick(4);
        check("reent_idx1", 32'(disp_idx), 32'd1);
        tick(20);
        check("reent_idx6", 32'(disp_idx), 32'd6);
        check("reent_cnt3_zero", disp_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perf_counter_display.md
# perf_counter_display

Parametrised performance-monitor and display-select block for the pipelined CPU FPGA build. Holds NUM_EVT saturating event counters, one per pulse input (cycles, jumps, branches, taken branches, load-use stalls, ...), plus NUM_EXT live 32-bit values (PC, memory data, syscall output). One channel is presented to the 7-segment driver. Three display modes: live select, frozen snapshot, timed auto-rotate.

## Interface
Parameters:
- NUM_EVT, 6, number of internal event counters (1..16)
- NUM_EXT, 3, number of external 32-bit display sources (1..8)
- CNT_W, 32, counter width (8..32); zero-extended to 32 on display
- SEL_W, 5, channel-select width; must satisfy 2^SEL_W >= NUM_EXT+NUM_EVT
- ROT_CYCLES, 50_000_000, clock cycles per channel in auto-rotate mode (>=2)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  counting enable (low while CPU halted)
- evt  in  NUM_EVT  one-cycle event pulses; bit i feeds counter i
- ext_data  in  32*NUM_EXT  live values; slice k = bits [32k+31:32k]
- sel  in  SEL_W  channel select for live/freeze modes
- mode  in  2  00 live, 01 freeze, 10 auto-rotate, 11 treated as live
- clr  in  1  synchronous clear of all counters and ovf flags
- disp_data  out  32  registered display value
- disp_idx  out  SEL_W  channel currently shown in disp_data
- ovf  out  NUM_EVT  sticky saturation flag per counter

## Operation
- Channel map: ch 0..NUM_EXT-1 = ext_data slices; ch NUM_EXT..NUM_EXT+NUM_EVT-1 = counters 0..NUM_EVT-1; any higher ch displays 32'h0.
- Counter i per cycle, priority order: rst or clr -> 0, ovf[i]=0; else run & evt[i] & cnt<max -> cnt+1; else run & evt[i] & cnt==max -> hold max, ovf[i]=1; else hold. clr with simultaneous event: clear wins, event lost.
- Live (00/11): disp_data <= value of channel sel; disp_idx <= sel.
- Freeze (01): on the first cycle mode==01 after a non-01 cycle, all counters copy into shadow registers (value before that cycle's increment). While frozen, counter channels show shadow values; ext channels stay live; counters keep counting. sel still selects. clr during freeze clears live counters only; shadows persist until next freeze entry.
- Auto-rotate (10): sel ignored. On entry (first 10 cycle after non-10), rot_idx=0, timer=0. Timer counts 0..ROT_CYCLES-1; at ROT_CYCLES-1 it returns to 0 and rot_idx increments, wrapping NUM_EXT+NUM_EVT-1 -> 0. Rotate displays live values. disp_idx <= rot_idx.
- Leaving rotate or freeze returns immediately to live behaviour the next cycle.

## Timing
- Reset values: disp_data=0, disp_idx=0, ovf=0, all counters, shadows, rot_idx, timer = 0; mode history registers treated as "live" after reset.
- sel change to disp_data/disp_idx: 1 cycle latency.
- Event pulse at cycle t: counter updated at edge t+1, visible on disp_data at edge t+2 if selected.
- ext_data change to disp_data: 1 cycle.
- Freeze entry at cycle t: disp_data reflects shadow from edge t+2.
- Rotate: each channel shown for exactly ROT_CYCLES cycles; first channel (0) appears on disp_data 1 cycle after entry.
- rst mid-rotate or mid-freeze: all state to reset values next edge; mode re-entry detection restarts.

## Test plan
- Reset/live: rst 2 cycles, NUM_EXT=3, ext slice 1=32'h0040_0010, sel=1 -> disp_data=0 during reset, 32'h0040_0010 and disp_idx=1 one cycle after; sel=31 -> 0.
- Counting: run=1, 10 pulses on evt[2], run=0 for 5 more pulses, sel=5 -> disp_data=10; clr pulse -> 0 two cycles later.
- Saturation: CNT_W=8, 300 pulses on evt[0] -> counter shows 32'h0000_00FF, ovf[0]=1; clr -> ovf=0; clr and evt same cycle -> counter 0.
- Freeze: counter 3 at 100, mode=01, keep pulsing 20 times, sel=6 -> disp_data=100 throughout; mode=00 -> 120.
- Auto-rotate: ROT_CYCLES=4, NUM_EXT+NUM_EVT=9 -> disp_idx sequence 0,1,..,8,0 each held 4 cycles; sel toggling has no effect; mode=00 mid-run -> disp_idx=sel next cycle.
- Reset mid-rotate: rst at rot_idx=5 -> disp_idx=0, counters 0; re-enter rotate starts at ch 0.
